// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

    localparam int DROP_CNT_W = 16;

    // Ceiling log2, never below 1 so single-entry indices still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr, wrapping.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_REQ-1:0]    gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!any && valid[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = ID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of the dual-clock FIFO write port.
// Define FIFO_WR_ARB_TAG_EN to prepend the source index to every written word.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 36,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = clog2(N_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int FW        = DATA_WIDTH + ID_WIDTH
`else
    localparam int FW        = DATA_WIDTH
`endif
) (
    input  logic                        wr_clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_last_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        fifo_full_i,
    input  logic                        fifo_afull_i,
    output logic                        fifo_wr_en_o,
    output logic [FW-1:0]               fifo_wr_data_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        busy_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_e            state;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   owner;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic [ID_WIDTH-1:0]   pick_ptr;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [N_REQ-1:0]      pick_gnt;
    logic                  pick_any;
    logic [CW-1:0]         burst_cnt;
    logic                  stall;
    logic                  owner_valid;
    logic                  xfer;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [FW-1:0]         word;

    assign stall       = fifo_full_i | fifo_afull_i;
    assign owner_valid = req_valid_i[owner];
    assign owner_data  = req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer        = (state == GRANT) & owner_valid & ~stall;
    assign burst_end   = xfer & (req_last_i[owner] | (burst_cnt == CW'(MAX_BURST - 1)));
    assign next_ptr    = (owner == ID_WIDTH'(N_REQ - 1)) ? '0 : owner + 1'b1;
    // While granted the picker only matters at burst end, searching past the owner.
    assign pick_ptr    = (state == GRANT) ? next_ptr : ptr;

`ifdef FIFO_WR_ARB_TAG_EN
    assign word = {owner, owner_data};
`else
    assign word = owner_data;
`endif

    always_comb begin
        req_ready_o = '0;
        if (state == GRANT) req_ready_o[owner] = ~stall;
    end

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            grant_o        <= '0;
            busy_o         <= 1'b0;
            owner          <= '0;
            ptr            <= '0;
            burst_cnt      <= '0;
            fifo_wr_en_o   <= 1'b0;
            fifo_wr_data_o <= '0;
            drop_cnt_o     <= '0;
        end else begin
            fifo_wr_en_o <= xfer;
            if (xfer) fifo_wr_data_o <= word;
            if ((state == GRANT) && owner_valid && stall && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + 1'b1;

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= GRANT;
                        grant_o <= pick_gnt;
                        owner   <= pick_idx;
                        busy_o  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        ptr       <= next_ptr;
                        burst_cnt <= '0;
                        if (pick_any) begin
                            grant_o <= pick_gnt;
                            owner   <= pick_idx;
                        end else begin
                            state   <= IDLE;
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                        end
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter against a queue-based arbitration model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 36;
    localparam int MB    = 16;
    localparam int IW    = 2;
    localparam int DEPTH = 512;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int FW = DW + IW;
`else
    localparam int FW = DW;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] d;
    } word_t;

    logic              wr_clk, rst;
    logic [N-1:0]      req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0]   req_data;
    logic              fifo_full, fifo_afull, fifo_wr_en, busy;
    logic [FW-1:0]     fifo_wr_data;
    logic [15:0]       drop_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk_i(wr_clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .fifo_full_i(fifo_full), .fifo_afull_i(fifo_afull),
        .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data),
        .grant_o(grant), .busy_o(busy), .drop_cnt_o(drop_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    word_t         lq [N][$];
    logic [FW-1:0] exp_q[$], obs_q[$];
    logic [N-1:0]  gnt_log[$];
    bit            wen_log[$];
    int  n_cmp, n_bad;
    int  lat_err, stray_hs, rdy_flag, wr_full, fcount;
    bit  prev_hs;

    function automatic logic [FW-1:0] mk_word(input int lane, input logic [DW-1:0] d);
`ifdef FIFO_WR_ARB_TAG_EN
        return {IW'(lane), d};
`else
        return FW'(d);
`endif
    endfunction

    task automatic load_lane(input int lane, input int nwords, input int bmin, input int bmax);
        int left, b, seq;
        word_t w;
        left = nwords;
        seq  = 0;
        while (left > 0) begin
            b = $urandom_range(bmin, bmax);
            if (b > left) b = left;
            for (int i = 0; i < b; i++) begin
                w.d    = {4'(lane), 16'(seq), 16'($urandom)};
                w.last = (i == b - 1);
                lq[lane].push_back(w);
                seq++;
            end
            left -= b;
        end
    endtask

    // Reference order: round robin over lanes holding data, each grant taking
    // words until a last marker or MB words, pointer moving past the owner.
    task automatic build_exp(input int maxw);
        word_t tmp [N][$];
        word_t w;
        int ptr, k, n;
        bit found, stop;
        exp_q.delete();
        for (int i = 0; i < N; i++) tmp[i] = lq[i];
        ptr = 0;
        k   = 0;
        while (exp_q.size() < maxw) begin
            found = 0;
            for (int i = 0; i < N; i++)
                if (!found && tmp[(ptr + i) % N].size() > 0) begin
                    found = 1;
                    k = (ptr + i) % N;
                end
            if (!found) break;
            n    = 0;
            stop = 0;
            while (!stop) begin
                w = tmp[k].pop_front();
                exp_q.push_back(mk_word(k, w.d));
                n++;
                stop = w.last || (n == MB) || (tmp[k].size() == 0) || (exp_q.size() >= maxw);
            end
            ptr = (k + 1) % N;
        end
    endtask

    task automatic clear_state();
        req_valid = '0; req_data = '0; req_last = '0;
        fifo_full = 1'b0; fifo_afull = 1'b0;
        for (int k = 0; k < N; k++) lq[k].delete();
        exp_q.delete(); obs_q.delete(); gnt_log.delete(); wen_log.delete();
        lat_err = 0; stray_hs = 0; rdy_flag = 0; wr_full = 0; fcount = 0; prev_hs = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_state();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        rst = 1'b0;
    endtask

    // mode 0: flags low except afull window; 1: random flags; 2: 512-deep FIFO model.
    task automatic run(input int ncyc, input int mode, input int ws, input int wl, input int stop_at);
        logic [N-1:0] hs;
        bit wen_now;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge wr_clk);
            case (mode)
                1: begin
                    fifo_full  = ($urandom_range(0, 15) == 0);
                    fifo_afull = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    fifo_full  = (fcount >= DEPTH);
                    fifo_afull = (fcount >= DEPTH - 1);
                end
                default: begin
                    fifo_full  = 1'b0;
                    fifo_afull = (c >= ws) && (c < ws + wl);
                end
            endcase
            for (int k = 0; k < N; k++) begin
                req_valid[k] = (lq[k].size() > 0);
                req_last[k]  = req_valid[k] ? lq[k][0].last : 1'b0;
                req_data[k*DW +: DW] = req_valid[k] ? lq[k][0].d : '0;
            end
            #1;
            hs = req_valid & req_ready;
            if (fifo_wr_en) begin
                obs_q.push_back(fifo_wr_data);
                if (mode == 2 && fifo_full) wr_full++;
            end
            if (fifo_wr_en !== prev_hs) lat_err++;
            if ((hs & ~grant) != '0) stray_hs++;
            if ((req_ready != '0) && (fifo_full || fifo_afull)) rdy_flag++;
            gnt_log.push_back(grant);
            wen_log.push_back(fifo_wr_en);
            wen_now = fifo_wr_en;
            prev_hs = |hs;
            @(posedge wr_clk);
            if (mode == 2 && wen_now) fcount++;
            for (int k = 0; k < N; k++) if (hs[k]) void'(lq[k].pop_front());
            if (stop_at > 0 && obs_q.size() >= stop_at) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_state();
        @(negedge wr_clk); #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
        n_cmp++; if (fifo_wr_data !== '0) begin n_bad++; $display("FAIL rst_wr_data got %h want 0", fifo_wr_data); end
        n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL rst_grant got %b want 0", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
        @(negedge wr_clk);
        rst = 1'b0;
        run(3, 0, 0, 0, 0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL idle_writes got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_single_burst();
        int badc, run_len, best;
        do_reset();
        load_lane(0, 20, 20, 20);
        build_exp(1000);
        run(26, 0, 0, 0, 0);
        n_cmp++; if (obs_q.size() !== 20) begin n_bad++; $display("FAIL single_count got %0d want 20", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        badc = -1;
        for (int c = 1; c < gnt_log.size(); c++) if (badc < 0 && gnt_log[c] !== 4'b0001) badc = c;
        n_cmp++; if (badc >= 0) begin n_bad++; $display("FAIL single_grant cycle %0d got %b want 0001", badc, gnt_log[badc]); end
        run_len = 0; best = 0;
        for (int c = 0; c < wen_log.size(); c++) begin
            run_len = wen_log[c] ? run_len + 1 : 0;
            if (run_len > best) best = run_len;
        end
        n_cmp++; if (best !== 20) begin n_bad++; $display("FAIL single_gapless got run %0d want 20", best); end
        n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL single_latency got %0d errors want 0", lat_err); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] rv[$];
        int           rl[$];
        logic [N-1:0] want_g [5];
        logic [N-1:0] last_g;
        want_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < N; k++) load_lane(k, 6, 3, 3);
        build_exp(1000);
        run(40, 0, 0, 0, 0);
        n_cmp++; if (obs_q.size() !== 24) begin n_bad++; $display("FAIL b2b_count got %0d want 24", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        last_g = '0;
        foreach (gnt_log[c]) begin
            if (gnt_log[c] != '0) begin
                if (rv.size() > 0 && gnt_log[c] == last_g) rl[rl.size() - 1] = rl[rl.size() - 1] + 1;
                else begin rv.push_back(gnt_log[c]); rl.push_back(1); end
            end
            last_g = gnt_log[c];
        end
        n_cmp++;
        if (rv.size() < 5) begin n_bad++; $display("FAIL b2b_grants got %0d runs want >=5", rv.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rv[i] !== want_g[i]) begin n_bad++; $display("FAIL b2b_order[%0d] got %b want %b", i, rv[i], want_g[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rl[i] !== 3) begin n_bad++; $display("FAIL b2b_burst_len[%0d] got %0d want 3", i, rl[i]); end
            end
        end
    endtask

    task automatic test_afull_stall();
        int wen_in_win;
        do_reset();
        load_lane(2, 12, 12, 12);
        build_exp(1000);
        run(24, 0, 4, 5, 0);
        n_cmp++; if (drop_cnt !== 16'd5) begin n_bad++; $display("FAIL stall_drop got %0d want 5", drop_cnt); end
        n_cmp++; if (rdy_flag !== 0) begin n_bad++; $display("FAIL stall_ready got %0d cycles want 0", rdy_flag); end
        wen_in_win = 0;
        for (int c = 5; c < 10; c++) wen_in_win += wen_log[c];
        n_cmp++; if (wen_in_win !== 0) begin n_bad++; $display("FAIL stall_wr_en got %0d writes want 0", wen_in_win); end
        n_cmp++; if (obs_q.size() !== 12) begin n_bad++; $display("FAIL stall_count got %0d want 12", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fifo_fill();
        do_reset();
        for (int k = 0; k < N; k++) load_lane(k, 150, 1, 20);
        build_exp(DEPTH);
        run(700, 2, 0, 0, 0);
        n_cmp++; if (obs_q.size() !== DEPTH) begin n_bad++; $display("FAIL fill_count got %0d want %0d", obs_q.size(), DEPTH); end
        n_cmp++; if (fcount !== DEPTH) begin n_bad++; $display("FAIL fill_level got %0d want %0d", fcount, DEPTH); end
        n_cmp++; if (wr_full !== 0) begin n_bad++; $display("FAIL fill_overflow got %0d writes while full want 0", wr_full); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fill_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < N; k++) load_lane(k, $urandom_range(20, 60), 1, 20);
        build_exp(100000);
        run(1500, 1, 0, 0, 0);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (lat_err !== 0) begin n_bad++; $display("FAIL rand_latency got %0d errors want 0", lat_err); end
        n_cmp++; if (stray_hs !== 0) begin n_bad++; $display("FAIL rand_non_owner got %0d accepts want 0", stray_hs); end
        n_cmp++; if (rdy_flag !== 0) begin n_bad++; $display("FAIL rand_ready_flag got %0d cycles want 0", rdy_flag); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load_lane(1, 3, 3, 3);
        load_lane(1, 10, 10, 10);
        build_exp(1000);
        run(40, 0, 0, 0, 10);
        n_cmp++; if (obs_q.size() < 10) begin n_bad++; $display("FAIL mid_reach got %0d writes want >=10", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        @(negedge wr_clk);
        rst = 1'b1;
        clear_state();
        #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_wr_en got %b want 0", fifo_wr_en); end
        n_cmp++; if (fifo_wr_data !== '0) begin n_bad++; $display("FAIL mid_rst_data got %h want 0", fifo_wr_data); end
        n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL mid_rst_grant got %b want 0", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        rst = 1'b0;
        load_lane(0, 2, 2, 2);
        load_lane(3, 2, 2, 2);
        build_exp(1000);
        run(12, 0, 0, 0, 0);
        n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL post_rst_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL post_rst_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_afull_stall();
        test_fifo_fill();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
